// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU: it arbitrates, registers the
// operands, captures the ALU result and returns it to the requester that owns it.
module alu_arbiter #(
  parameter int OP_MAX     = 16,
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [31:0] s0_a,
  input  logic [31:0] s0_b,
  input  logic [4:0]  s0_op,
  input  logic        s1_valid,
  output logic        s1_ready,
  input  logic [31:0] s1_a,
  input  logic [31:0] s1_b,
  input  logic [4:0]  s1_op,
  output logic        r0_valid,
  input  logic        r0_ready,
  output logic        r1_valid,
  input  logic        r1_ready,
  output logic [31:0] r_out,
  output logic        r_zero,
  output logic        r_sml,
  output logic        r_ovf,
  output logic        r_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_sml,
  input  logic        alu_ovf,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [31:0] op_max_w = OP_MAX;

  state_t      state, state_next;
  logic        owner;
  logic        last_grant;
  logic        pend_err;
  logic        grant0, grant1, accept;
  logic [31:0] sel_a, sel_b;
  logic [4:0]  sel_op;
  logic        sel_illegal;
  logic        resp_done;

  // Ready is also gated by rst_n so nothing is offered while reset is held
  assign grant0 = rst_n && (state == IDLE) && s0_valid &&
                  (!s1_valid || PRIO_FIXED || last_grant);
  assign grant1 = rst_n && (state == IDLE) && s1_valid && !grant0;
  assign accept = grant0 || grant1;

  assign sel_a       = grant1 ? s1_a  : s0_a;
  assign sel_b       = grant1 ? s1_b  : s0_b;
  assign sel_op      = grant1 ? s1_op : s0_op;
  assign sel_illegal = {27'd0, sel_op} > op_max_w;

  assign resp_done = (state == RESP) && (owner ? r1_ready : r0_ready);

  assign r0_valid = (state == RESP) && !owner;
  assign r1_valid = (state == RESP) && owner;
  assign busy     = (state != IDLE);

  always_comb begin
    state_next = state;
    s0_ready   = 1'b0;
    s1_ready   = 1'b0;
    case (state)
      IDLE: begin
        s0_ready = grant0;
        s1_ready = grant1;
        if (accept) state_next = EXEC;
      end
      EXEC:    state_next = RESP;
      RESP:    if (resp_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      pend_err   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      r_out      <= '0;
      r_zero     <= 1'b0;
      r_sml      <= 1'b0;
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        owner      <= grant1;
        last_grant <= grant1;
        pend_err   <= sel_illegal;
        alu_a      <= sel_a;
        alu_b      <= sel_b;
        alu_op     <= sel_illegal ? 5'd0 : sel_op;
      end
      // Illegal opcodes still take a full slot but report a fixed error result
      if (state == EXEC) begin
        if (pend_err) begin
          r_out  <= '0;
          r_zero <= 1'b1;
          r_sml  <= 1'b0;
          r_ovf  <= 1'b0;
          r_err  <= 1'b1;
        end else begin
          r_out  <= alu_out;
          r_zero <= alu_zero;
          r_sml  <= alu_sml;
          r_ovf  <= alu_ovf;
          r_err  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance and a fixed-priority
// instance share the requester inputs, each driving its own simple ALU model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s0_valid, s1_valid, r0_ready, r1_ready;
  logic [31:0] s0_a, s0_b, s1_a, s1_b;
  logic [4:0]  s0_op, s1_op;

  logic        s0_ready, s1_ready, r0_valid, r1_valid, busy;
  logic [31:0] r_out, alu_a, alu_b, alu_out;
  logic        r_zero, r_sml, r_ovf, r_err, alu_zero, alu_sml, alu_ovf;
  logic [4:0]  alu_op;

  logic        s0_ready_f, s1_ready_f, r0_valid_f, r1_valid_f, busy_f;
  logic [31:0] r_out_f, alu_a_f, alu_b_f, alu_out_f;
  logic        r_zero_f, r_sml_f, r_ovf_f, r_err_f, alu_zero_f, alu_sml_f, alu_ovf_f;
  logic [4:0]  alu_op_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference ALU: op 0 add, op 1 subtract, anything else bitwise and
  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] op);
    logic [31:0] res;
    logic        ovf;
    case (op)
      5'd0: begin
        res = a + b;
        ovf = (a[31] == b[31]) && (res[31] != a[31]);
      end
      5'd1: begin
        res = a - b;
        ovf = (a[31] != b[31]) && (res[31] != a[31]);
      end
      default: begin
        res = a & b;
        ovf = 1'b0;
      end
    endcase
    return {res == 32'd0, $signed(a) < $signed(b), ovf, res};
  endfunction

  assign {alu_zero, alu_sml, alu_ovf, alu_out}         = alu_model(alu_a, alu_b, alu_op);
  assign {alu_zero_f, alu_sml_f, alu_ovf_f, alu_out_f} = alu_model(alu_a_f, alu_b_f, alu_op_f);

  alu_arbiter #(.OP_MAX(16), .PRIO_FIXED(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_a(s0_a), .s0_b(s0_b), .s0_op(s0_op),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_a(s1_a), .s1_b(s1_b), .s1_op(s1_op),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r1_valid(r1_valid), .r1_ready(r1_ready),
    .r_out(r_out), .r_zero(r_zero), .r_sml(r_sml), .r_ovf(r_ovf), .r_err(r_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .alu_zero(alu_zero), .alu_sml(alu_sml), .alu_ovf(alu_ovf), .busy(busy)
  );

  alu_arbiter #(.OP_MAX(16), .PRIO_FIXED(1'b1)) dut_fixed (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready_f), .s0_a(s0_a), .s0_b(s0_b), .s0_op(s0_op),
    .s1_valid(s1_valid), .s1_ready(s1_ready_f), .s1_a(s1_a), .s1_b(s1_b), .s1_op(s1_op),
    .r0_valid(r0_valid_f), .r0_ready(r0_ready), .r1_valid(r1_valid_f), .r1_ready(r1_ready),
    .r_out(r_out_f), .r_zero(r_zero_f), .r_sml(r_sml_f), .r_ovf(r_ovf_f), .r_err(r_err_f),
    .alu_a(alu_a_f), .alu_b(alu_b_f), .alu_op(alu_op_f), .alu_out(alu_out_f),
    .alu_zero(alu_zero_f), .alu_sml(alu_sml_f), .alu_ovf(alu_ovf_f), .busy(busy_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    s0_valid = 1'b0; s1_valid = 1'b0; r0_ready = 1'b0; r1_ready = 1'b0;
    s0_a = '0; s0_b = '0; s0_op = '0; s1_a = '0; s1_b = '0; s1_op = '0;

    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_r_out", r_out, 32'd0);
    check("rst_flags", {28'd0, r_zero, r_sml, r_ovf, r_err}, 32'd0);
    check("rst_rvalid", {30'd0, r0_valid, r1_valid}, 32'd0);
    check("rst_sready", {30'd0, s0_ready, s1_ready}, 32'd0);

    // Single add from requester 0, then hold the result for 10 cycles
    #10;
    rst_n = 1'b1;
    s0_valid = 1'b1; s0_a = 32'd5; s0_b = 32'd3; s0_op = 5'd0;
    #1;
    check("add_s0_ready", {30'd0, s0_ready, s1_ready}, 32'd2);
    tick();
    check("add_exec_busy", 32'(busy), 32'd1);
    check("add_alu_a", alu_a, 32'd5);
    check("add_alu_b", alu_b, 32'd3);
    check("add_exec_sready", {30'd0, s0_ready, s1_ready}, 32'd0);
    check("add_exec_rvalid", {30'd0, r0_valid, r1_valid}, 32'd0);
    tick();
    check("add_rvalid", {30'd0, r0_valid, r1_valid}, 32'd2);
    check("add_r_out", r_out, 32'd8);
    check("add_zero_err", {30'd0, r_zero, r_err}, 32'd0);
    s1_valid = 1'b1; r1_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_r_out", r_out, 32'd8);
      check("hold_sready", {30'd0, s0_ready, s1_ready}, 32'd0);
      check("hold_busy_r0v", {30'd0, busy, r0_valid}, 32'd3);
      check("hold_alu_a", alu_a, 32'd5);
    end
    s0_valid = 1'b0; r0_ready = 1'b1;
    s1_a = 32'h7FFF_FFFF; s1_b = 32'd1; s1_op = 5'd0;
    tick();
    check("release_busy", 32'(busy), 32'd0);
    check("release_rvalid", {30'd0, r0_valid, r1_valid}, 32'd0);
    check("s1_ready", {30'd0, s0_ready, s1_ready}, 32'd1);
    r0_ready = 1'b0;

    // Signed overflow from requester 1
    tick();
    tick();
    check("ovf_rvalid", {30'd0, r0_valid, r1_valid}, 32'd1);
    check("ovf_r_out", r_out, 32'h8000_0000);
    check("ovf_flags", {28'd0, r_zero, r_sml, r_ovf, r_err}, 32'd2);
    s1_op = 5'b11111;
    tick();
    check("ill_ready", {30'd0, s0_ready, s1_ready}, 32'd1);

    // Illegal opcode, then the OP_MAX boundary which is still legal
    tick();
    check("ill_alu_op", 32'(alu_op), 32'd0);
    tick();
    check("ill_r_out", r_out, 32'd0);
    check("ill_flags", {28'd0, r_zero, r_sml, r_ovf, r_err}, 32'd9);
    check("ill_rvalid", {30'd0, r0_valid, r1_valid}, 32'd1);
    s1_op = 5'd16;
    tick();
    tick();
    check("max_alu_op", 32'(alu_op), 32'd16);
    tick();
    check("max_r_err", 32'(r_err), 32'd0);
    check("max_r_out", r_out, 32'd1);
    s1_valid = 1'b0;
    tick();

    // Reset while in EXEC discards the operation
    s0_valid = 1'b1; s0_a = 32'd5; s0_b = 32'd3; s0_op = 5'd0;
    tick();
    s0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_alu_a", alu_a, 32'd0);
    check("mid_rst_r_out", r_out, 32'd0);
    check("mid_rst_rvalid", {30'd0, r0_valid, r1_valid}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_rvalid", {30'd0, r0_valid, r1_valid}, 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end

    // Both requesters always valid: round-robin alternates, fixed priority starves 1
    s0_valid = 1'b1; s0_a = 32'd10; s0_b = 32'd1; s0_op = 5'd0;
    s1_valid = 1'b1; s1_a = 32'h7FFF_FFFF; s1_b = 32'd1; s1_op = 5'd0;
    r0_ready = 1'b1; r1_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rr_grant", {30'd0, s0_ready, s1_ready}, (i % 2 == 0) ? 32'd2 : 32'd1);
      check("fix_grant", {30'd0, s0_ready_f, s1_ready_f}, 32'd2);
      tick();
      tick();
      check("rr_route", {30'd0, r0_valid, r1_valid}, (i % 2 == 0) ? 32'd2 : 32'd1);
      check("rr_r_out", r_out, (i % 2 == 0) ? 32'd11 : 32'h8000_0000);
      check("fix_route", {30'd0, r0_valid_f, r1_valid_f}, 32'd2);
      check("fix_r_out", r_out_f, 32'd11);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
